// File: rtl/shift_issue_queue.sv
// shift_issue_queue: decodes MIPS R-type shifts into barrel-shifter controls
// and buffers them in a two-entry registered skid queue.
module shift_issue_queue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [4:0]       in_shamt,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      sh_d,
  output logic [4:0]       sh_sa,
  output logic             sh_right,
  output logic             sh_arith,
  output logic [4:0]       out_rd,
  output logic             ill_op,
  output logic [5:0]       ill_funct,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
  } ent_t;

  ent_t       q [2];
  ent_t       new_e;
  ent_t       head_e;
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       legal;
  logic       accept;
  logic       push;
  logic       pop;
  logic       ill;
  logic       unused_rs;

  always_comb begin
    legal = 1'b0;
    case (in_funct)
      6'b000000,
      6'b000010,
      6'b000011,
      6'b000100,
      6'b000110,
      6'b000111: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready & ~flush;
  assign push      = accept & legal;
  assign ill       = accept & ~legal;
  assign pop       = out_valid & out_ready & ~flush;

  // funct[2] selects the variable (register) shift amount
  always_comb begin
    new_e.d     = in_rt;
    new_e.sa    = in_funct[2] ? in_rs[4:0] : in_shamt;
    new_e.right = in_funct[1];
    new_e.arith = in_funct[0];
    new_e.rd    = in_rd;
  end

  assign unused_rs = ^in_rs[31:5];

  assign head_e   = q[head];
  assign sh_d     = head_e.d;
  assign sh_sa    = head_e.sa;
  assign sh_right = head_e.right;
  assign sh_arith = head_e.arith;
  assign out_rd   = head_e.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q[0]      <= '0;
      q[1]      <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      ill_op    <= 1'b0;
      ill_funct <= 6'd0;
      issue_cnt <= '0;
    end else begin
      ill_op <= ill;
      if (ill) ill_funct <= in_funct;
      if (pop && issue_cnt != '1)
        issue_cnt <= issue_cnt + CNT_W'(1);
      if (flush) begin
        head  <= 1'b0;
        tail  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          q[tail] <= new_e;
          tail    <= ~tail;
        end
        if (pop) head <= ~head;
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Scoreboard bench for shift_issue_queue: random and directed traffic
// checked against a table-driven model of the shift decode and FIFO.
module tb_shift_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_d;
  logic [4:0]  sh_sa;
  logic        sh_right;
  logic        sh_arith;
  logic [4:0]  out_rd;
  logic        ill_op;
  logic [5:0]  ill_funct;
  logic [15:0] issue_cnt;

  shift_issue_queue #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .sh_d(sh_d), .sh_sa(sh_sa), .sh_right(sh_right),
    .sh_arith(sh_arith), .out_rd(out_rd),
    .ill_op(ill_op), .ill_funct(ill_funct), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
  } ent_t;

  localparam logic [5:0] SLL  = 6'd0;
  localparam logic [5:0] SRL  = 6'd2;
  localparam logic [5:0] SRA  = 6'd3;
  localparam logic [5:0] SLLV = 6'd4;
  localparam logic [5:0] SRLV = 6'd6;
  localparam logic [5:0] SRAV = 6'd7;

  ent_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  bit          exp_ill = 1'b0;
  logic [5:0]  last_ill = 6'd0;
  logic [15:0] exp_cnt = 16'd0;
  bit          last_acc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] f);
    return f inside {SLL, SRL, SRA, SLLV, SRLV, SRAV};
  endfunction

  function automatic ent_t ref_entry(input op_t o);
    ent_t e;
    e.d = o.rt;
    e.rd = o.rd;
    e.sa = o.shamt;
    e.right = 1'b0;
    e.arith = 1'b0;
    case (o.funct)
      SLL:  e.sa = o.shamt;
      SRL:  begin e.right = 1'b1; e.sa = o.shamt; end
      SRA:  begin e.right = 1'b1; e.arith = 1'b1; e.sa = o.shamt; end
      SLLV: e.sa = o.rs[4:0];
      SRLV: begin e.right = 1'b1; e.sa = o.rs[4:0]; end
      SRAV: begin e.right = 1'b1; e.arith = 1'b1; e.sa = o.rs[4:0]; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] shifter(input logic [31:0] d,
      input logic [4:0] sa, input logic r, input logic a);
    if (!r) return d << sa;
    if (a) return $unsigned($signed(d) >>> sa);
    return d >> sa;
  endfunction

  // Model update for the cycle whose inputs are currently driven.
  task automatic model_step();
    op_t o;
    last_acc = in_valid && in_ready && !flush;
    exp_ill = last_acc && !is_legal(in_funct);
    if (flush) sb.delete();
    if (last_acc) begin
      o.funct = in_funct; o.rs = in_rs; o.rt = in_rt;
      o.shamt = in_shamt; o.rd = in_rd;
      if (is_legal(in_funct)) sb.push_back(ref_entry(o));
      else last_ill = in_funct;
    end
  endtask

  task automatic cyc(input bit v, input op_t o, input bit fl,
                     input bit ordy);
    in_valid = v; in_funct = o.funct; in_rs = o.rs; in_rt = o.rt;
    in_shamt = o.shamt; in_rd = o.rd; flush = fl; out_ready = ordy;
    @(negedge clk); #1;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    op_t o;
    o = '{SLL, 32'd0, 32'd0, 5'd0, 5'd0};
    cyc(1'b0, o, 1'b0, ordy);
  endtask

  task automatic send(input op_t o, input bit ordy);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, o, 1'b0, ordy);
      if (last_acc) return;
    end
    nvec++; nerr++;
    $display("FAIL send_timeout: got no accept expected accept");
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sh_d", sh_d, 0);
    chk("rst_sh_sa", sh_sa, 0);
    chk("rst_sh_right", sh_right, 0);
    chk("rst_sh_arith", sh_arith, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_ill_op", ill_op, 0);
    chk("rst_ill_funct", ill_funct, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    sb.delete();
    exp_ill = 1'b0; last_ill = 6'd0; exp_cnt = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT head and status against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, sb.size() != 2);
      chk("ill_op", ill_op, exp_ill);
      chk("ill_funct", ill_funct, last_ill);
      chk("issue_cnt", issue_cnt, exp_cnt);
      if (out_valid && sb.size() != 0) begin
        chk("sh_d", sh_d, sb[0].d);
        chk("sh_sa", sh_sa, sb[0].sa);
        chk("sh_right", sh_right, sb[0].right);
        chk("sh_arith", sh_arith, sb[0].arith);
        chk("out_rd", out_rd, sb[0].rd);
      end
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL pop_empty: got pop expected none");
        end else begin
          void'(sb.pop_front());
          if (exp_cnt != 16'hFFFF) exp_cnt++;
        end
      end
    end
  end

  initial begin
    op_t o;
    logic [15:0] base;
    logic [5:0] ftab [10];
    ftab = '{SLL, SRL, SRA, SLLV, SRLV, SRAV, 6'd1, 6'd5, 6'd0, 6'd0};
    in_valid = 0; in_funct = 0; in_rs = 0; in_rt = 0; in_shamt = 0;
    in_rd = 0; flush = 0; out_ready = 0;
    rst = 1'b1;
    #1;
    do_reset();

    o = '{SRA, 32'd0, 32'h8000_0000, 5'd4, 5'd7};
    cyc(1'b1, o, 1'b0, 1'b0);
    chk("sra_valid", out_valid, 1);
    chk("sra_result", shifter(sh_d, sh_sa, sh_right, sh_arith),
        32'hF800_0000);
    idle(1'b1); idle(1'b1);

    o = '{SLLV, 32'h0000_0023, 32'd1, 5'd17, 5'd9};
    cyc(1'b1, o, 1'b0, 1'b0);
    chk("sllv_sa", sh_sa, 3);
    chk("sllv_right", sh_right, 0);
    chk("sllv_arith", sh_arith, 0);
    idle(1'b1); idle(1'b1);

    base = exp_cnt;
    for (int r = 1; r <= 2; r++) begin
      o = '{SRL, 32'd0, 32'h1234_5678 + r, 5'(r), 5'(r)};
      send(o, 1'b0);
    end
    o = '{SRAV, 32'd5, 32'hF000_0003, 5'd0, 5'd3};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, o, 1'b0, 1'b0);
      chk("stall_third", last_acc, 0);
    end
    send(o, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_issue_cnt", issue_cnt, base + 16'd3);

    o = '{6'd5, 32'd1, 32'd2, 5'd3, 5'd4};
    cyc(1'b1, o, 1'b0, 1'b1);
    chk("ill_pulse", ill_op, 1);
    chk("ill_funct_ld", ill_funct, 6'd5);
    chk("ill_no_valid", out_valid, 0);
    idle(1'b1);
    chk("ill_one_cycle", ill_op, 0);
    o.funct = 6'd1;
    cyc(1'b1, o, 1'b0, 1'b1);
    o.funct = 6'd5;
    cyc(1'b1, o, 1'b0, 1'b1);
    idle(1'b1);

    for (int r = 1; r <= 2; r++) begin
      o = '{SLL, 32'd0, 32'hA5A5_0000 + r, 5'(r), 5'(r + 10)};
      send(o, 1'b0);
    end
    base = exp_cnt;
    o = '{SRLV, 32'd9, 32'd99, 5'd1, 5'd20};
    cyc(1'b1, o, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", issue_cnt, base);
    idle(1'b1);
    chk("flush_no_ill", ill_op, 0);

    for (int r = 1; r <= 2; r++) begin
      o = '{SRA, 32'd0, 32'hDEAD_0000 + r, 5'(r), 5'(r)};
      send(o, 1'b0);
    end
    do_reset();

    for (int i = 0; i < 600; i++) begin
      o.funct = ftab[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) o.funct = 6'($urandom);
      o.rs = $urandom; o.rt = $urandom;
      o.shamt = 5'($urandom); o.rd = 5'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), o,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
